// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the SEQ sequencer: instruction codes, status codes,
// sequencer state encoding and the memory-access classifier.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WRITEBACK, S_PCUPD, S_HALTED, S_ERROR
  } seq_state_t;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET) || (ic == I_PUSHQ) || (ic == I_POPQ);
  endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC selection applied in the PC-update step.
module seq_next_pc
  import y86_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [3:0]      icode,
  input  logic            cnd,
  input  logic [PC_W-1:0] valC,
  input  logic [PC_W-1:0] valP,
  input  logic [PC_W-1:0] valM,
  output logic [PC_W-1:0] new_pc
);

  always_comb begin
    new_pc = valP;
    unique case (icode)
      I_CALL:  new_pc = valC;
      I_JXX:   new_pc = cnd ? valC : valP;
      I_RET:   new_pc = valM;
      default: new_pc = valP;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle SEQ sequencer: owns the PC, walks each instruction through the six
// stages with one-cycle strobes, runs the data-memory handshake and tracks status.
module seq_ctrl
  import y86_pkg::*;
#(
  parameter int              PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              IMEM_BYTES = 1024,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [PC_W-1:0]  valC,
  input  logic [PC_W-1:0]  valP,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic [PC_W-1:0]  valM,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output seq_state_t       dbg_state
);

  seq_state_t      state;
  logic [3:0]      icode_q;
  logic [PC_W-1:0] valm_q;
  logic [PC_W-1:0] new_pc;
  logic            adr_fault;
  logic            ins_fault;
  logic            active;

  assign adr_fault = imem_error || (pc >= PC_W'(IMEM_BYTES));
  assign ins_fault = icode > I_POPQ;
  assign active    = (state != S_IDLE) && (state != S_HALTED) && (state != S_ERROR);
  assign dbg_state = state;

  // decode_en depends on the fetch fields that only become valid inside DECODE.
  assign decode_en = (state == S_DECODE) && !adr_fault && !ins_fault && (icode != I_HALT);

  seq_next_pc #(.PC_W(PC_W)) u_next_pc (
    .icode  (icode_q),
    .cnd    (cnd),
    .valC   (valC),
    .valP   (valP),
    .valM   (valm_q),
    .new_pc (new_pc)
  );

  // Data memory: mem_req is valid from MEMORY entry and stays high until the
  // cycle mem_ready is seen (inclusive); valM/dmem_error are sampled only then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      stat        <= STAT_AOK;
      halted      <= 1'b0;
      fetch_en    <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      mem_req     <= 1'b0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      icode_q     <= I_NOP;
      valm_q      <= '0;
    end else begin
      fetch_en <= 1'b0;
      exec_en  <= 1'b0;
      mem_en   <= 1'b0;
      wb_en    <= 1'b0;
      if (active && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            fetch_en <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          icode_q <= icode;
          if (adr_fault) begin
            stat   <= STAT_ADR;
            halted <= 1'b1;
            state  <= S_ERROR;
          end else if (ins_fault) begin
            stat   <= STAT_INS;
            halted <= 1'b1;
            state  <= S_ERROR;
          end else if (icode == I_HALT) begin
            stat   <= STAT_HLT;
            halted <= 1'b1;
            state  <= S_HALTED;
            if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_W'(1);
          end else begin
            state   <= S_EXECUTE;
            exec_en <= 1'b1;
          end
        end
        S_EXECUTE: begin
          state   <= S_MEMORY;
          mem_en  <= 1'b1;
          mem_req <= is_mem_icode(icode_q);
        end
        S_MEMORY: begin
          if (!mem_req) begin
            state <= S_WRITEBACK;
            wb_en <= 1'b1;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            if (dmem_error) begin
              stat   <= STAT_ADR;
              halted <= 1'b1;
              state  <= S_ERROR;
            end else begin
              valm_q <= valM;
              state  <= S_WRITEBACK;
              wb_en  <= 1'b1;
            end
          end
        end
        S_WRITEBACK: state <= S_PCUPD;
        S_PCUPD: begin
          pc       <= new_pc;
          state    <= S_FETCH;
          fetch_en <= 1'b1;
          if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_W'(1);
        end
        S_HALTED, S_ERROR: ;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed and random instruction streams checked against a
// per-instruction reference model of PC, status, counters and strobe timing.
module tb_seq_ctrl;
  import y86_pkg::*;

  localparam int PC_W       = 64;
  localparam int CNT_W      = 32;
  localparam int IMEM_BYTES = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       icode = 4'h1;
  logic [PC_W-1:0]  valC = '0, valP = '0, valM = '0;
  logic             imem_error = 1'b0, cnd = 1'b0, mem_ready = 1'b0, dmem_error = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req, halted;
  logic [2:0]       stat;
  logic [CNT_W-1:0] cycle_cnt, retired_cnt;
  seq_state_t       dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] pc_m;
  logic [2:0]      stat_m;
  logic [31:0]     ret_m, cyc_m;

  seq_ctrl #(.PC_W(PC_W), .RESET_PC(64'h0), .IMEM_BYTES(IMEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .valC(valC), .valP(valP),
    .imem_error(imem_error), .cnd(cnd), .valM(valM), .mem_ready(mem_ready),
    .dmem_error(dmem_error), .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .mem_req(mem_req), .stat(stat),
    .halted(halted), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 64'h0);
    chk({tag, "_stat"}, 64'(stat), 64'(STAT_AOK));
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_strobes"}, 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, mem_req}), 64'd0);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    chk({tag, "_retired_cnt"}, 64'(retired_cnt), 64'd0);
  endtask

  task automatic model_reset;
    pc_m = 64'h0; stat_m = STAT_AOK; ret_m = 0; cyc_m = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_next_pc(input logic [3:0] ic, input logic cd,
                                              input logic [63:0] c, input logic [63:0] p,
                                              input logic [63:0] m);
    if (ic == 4'h8 || (ic == 4'h7 && cd)) return c;
    if (ic == 4'h9) return m;
    return p;
  endfunction

  task automatic check_state(input string tag);
    logic [63:0] exp_pc;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      exp_pc = pc_m;
    end else begin
      exp_pc = exp_q.pop_front();
    end
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_stat"}, 64'(stat), 64'(stat_m));
    chk({tag, "_halted"}, 64'(halted), 64'(stat_m != STAT_AOK));
    chk({tag, "_retired"}, 64'(retired_cnt), 64'(ret_m));
    chk({tag, "_cycles"}, 64'(cycle_cnt), 64'(cyc_m));
  endtask

  // ---------------- driver: one instruction from its FETCH cycle ----------------
  task automatic run_instr(input string tag, input logic [3:0] ic, input logic [63:0] c,
                           input logic [63:0] p, input logic [63:0] m, input logic cd,
                           input int d, input logic derr, input logic ierr);
    int cyc = 0;
    int f_at = 0, dd_at = 0, e_at = 0, m_at = 0, w_at = 0;
    int f_n = 0, dd_n = 0, e_n = 0, m_n = 0, w_n = 0, req_n = 0;
    int xf, xd, xe, xm, xw, xreq, dwait;
    logic wb_prev = 1'b0;
    logic done = 1'b0;
    logic is_mem;

    is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic >= 4'h8 && ic <= 4'hB);
    dwait  = is_mem ? d : 0;
    xf = 1; xd = 0; xe = 0; xm = 0; xw = 0; xreq = 0;
    if (ierr || pc_m >= 64'(IMEM_BYTES)) begin
      stat_m = STAT_ADR; cyc_m += 2;
    end else if (ic > 4'hB) begin
      stat_m = STAT_INS; cyc_m += 2;
    end else if (ic == 4'h0) begin
      stat_m = STAT_HLT; cyc_m += 2; ret_m++;
    end else if (is_mem && derr) begin
      stat_m = STAT_ADR; cyc_m += 4 + d;
      xd = 2; xe = 3; xm = 4; xreq = d + 1;
    end else begin
      cyc_m += 6 + dwait; ret_m++;
      pc_m = ref_next_pc(ic, cd, c, p, m);
      xd = 2; xe = 3; xm = 4; xw = 5 + dwait; xreq = is_mem ? d + 1 : 0;
    end
    exp_q.push_back(pc_m);

    icode = ic; valC = c; valP = p; valM = m; cnd = cd; imem_error = ierr;
    mem_ready = 1'b0; dmem_error = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (fetch_en)  begin f_n++;  f_at = cyc;  end
      if (decode_en) begin dd_n++; dd_at = cyc; end
      if (exec_en)   begin e_n++;  e_at = cyc;  end
      if (mem_en)    begin m_n++;  m_at = cyc;  end
      if (wb_en)     begin w_n++;  w_at = cyc;  end
      if (mem_req) req_n++;
      mem_ready  = mem_req && (req_n == d + 1);
      dmem_error = mem_ready && derr;
      if (halted) done = 1'b1;
      else if (wb_prev) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
      wb_prev = wb_en;
    end
    mem_ready = 1'b0; dmem_error = 1'b0;

    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_strobe_cnt"},
        {24'd0, f_n[7:0], dd_n[7:0], e_n[7:0], m_n[7:0], w_n[7:0]},
        {24'd0, 8'd1, 8'(xd != 0), 8'(xe != 0), 8'(xm != 0), 8'(xw != 0)});
    chk({tag, "_strobe_pos"},
        {24'd0, f_at[7:0], dd_at[7:0], e_at[7:0], m_at[7:0], w_at[7:0]},
        {24'd0, xf[7:0], xd[7:0], xe[7:0], xm[7:0], xw[7:0]});
    chk({tag, "_mem_req_cycles"}, 64'(req_n), 64'(xreq));
    check_state(tag);
  endtask

  task automatic check_start_ignored(input string tag);
    logic any_strobe = 1'b0;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      any_strobe |= fetch_en | decode_en | exec_en | mem_en | wb_en | mem_req;
    end
    start = 1'b0;
    chk({tag, "_no_strobes"}, 64'(any_strobe), 64'd0);
    exp_q.push_back(pc_m);
    check_state(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    do_reset("reset0");

    do_start();
    run_instr("nop", 4'h1, 64'h0, 64'h1, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    run_instr("jxx_taken", 4'h7, 64'h20, 64'h2B, 64'h0, 1'b1, 0, 1'b0, 1'b0);
    run_instr("jxx_not_taken", 4'h7, 64'h20, 64'h2B, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    run_instr("ret_wait3", 4'h9, 64'h0, 64'h30, 64'h40, 1'b0, 3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_instr("rand", 4'($urandom_range(1, 11)), 64'($urandom_range(0, IMEM_BYTES - 1)),
                64'($urandom_range(0, IMEM_BYTES - 1)), 64'($urandom_range(0, IMEM_BYTES - 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // Jump to the first address past instruction memory, then fault on fetch.
    run_instr("call_edge", 4'h8, 64'(IMEM_BYTES), 64'h5, 64'h0, 1'b0, 1, 1'b0, 1'b0);
    run_instr("pc_out_of_range", 4'h1, 64'h0, 64'h0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check_start_ignored("adr_frozen");

    do_reset("reset1");
    do_start();
    run_instr("nop_to_10", 4'h1, 64'h0, 64'h10, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    run_instr("bad_icode", 4'hC, 64'h0, 64'h11, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check_start_ignored("ins_frozen");

    do_reset("reset2");
    do_start();
    run_instr("nop_to_10b", 4'h1, 64'h0, 64'h10, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    run_instr("halt", 4'h0, 64'h0, 64'h11, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check_start_ignored("hlt_frozen");

    do_reset("reset3");
    do_start();
    run_instr("rmmovq_dmem_err", 4'h4, 64'h100, 64'hA, 64'h0, 1'b0, 1, 1'b1, 1'b0);

    do_reset("reset4");
    do_start();
    run_instr("imem_err", 4'h1, 64'h0, 64'h1, 64'h0, 1'b0, 0, 1'b0, 1'b1);

    // Asynchronous reset while a memory request is outstanding.
    do_reset("reset5");
    do_start();
    icode = 4'h4; valC = 64'h80; valP = 64'hA; imem_error = 1'b0;
    mem_ready = 1'b0; dmem_error = 1'b0;
    begin
      int k = 0;
      while (!mem_req && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    chk("mem_req_before_reset", 64'(mem_req), 64'd1);
    #2;
    do_reset("reset_mid_mem");
    do_start();
    run_instr("restart_nop", 4'h1, 64'h0, 64'h8, 64'h0, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
